// File: rtl/superscalar_pkg.sv
// Shared definitions for the superscalar back end.
//   ROB_DEPTH / TAG_W  : default reorder-buffer depth and physical tag width
//   ARCH_REGS / RD_W   : architectural register count and index width
//   rob_status_t       : per-entry state seen by the commit selector
//   add2()             : population count of two request bits
package superscalar_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 6;
  localparam int ARCH_REGS = 32;
  localparam int RD_W      = $clog2(ARCH_REGS);

  typedef struct packed {
    logic valid;
    logic done;
    logic has_rd;
  } rob_status_t;

  function automatic logic [1:0] add2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Chooses which of the two oldest ROB entries retire this cycle and which
// (if any) old physical register is returned to the freelist.
//   head0_i / head1_i : status of the entries at head and head+1
//   retire_0_o        : head entry retires
//   retire_1_o        : head+1 entry retires alongside it
//   free_valid_o      : one retiring entry releases its old mapping
//   free_from_1_o     : the released mapping belongs to head+1
module rob_commit_select
  import superscalar_pkg::*;
(
  input  rob_status_t head0_i,
  input  rob_status_t head1_i,
  output logic        retire_0_o,
  output logic        retire_1_o,
  output logic        free_valid_o,
  output logic        free_from_1_o
);

  always_comb begin
    retire_0_o    = 1'b0;
    retire_1_o    = 1'b0;
    free_valid_o  = 1'b0;
    free_from_1_o = 1'b0;

    retire_0_o = head0_i.valid && head0_i.done;
    // Only one freelist port: two register writers cannot retire together.
    retire_1_o = retire_0_o && head1_i.valid && head1_i.done &&
                 !(head0_i.has_rd && head1_i.has_rd);

    if (retire_0_o && head0_i.has_rd) begin
      free_valid_o = 1'b1;
    end else if (retire_1_o && head1_i.has_rd) begin
      free_valid_o  = 1'b1;
      free_from_1_o = 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Two-wide reorder buffer: in-order allocation at tail, out-of-order
// completion marks, in-order retirement of up to two entries per cycle.
//   alloc_*  : dispatch of up to two instructions (slot 1 needs slot 0)
//   wb_*     : two completion ports marking entries done
//   flush    : discards every entry
//   commit_* : registered retirement to the rename map, program order
//   free_*   : registered release of one old physical register
//   count / empty / full : registered occupancy
module reorder_buffer
  import superscalar_pkg::*;
#(
  parameter int DEPTH     = ROB_DEPTH,
  parameter int TAG_WIDTH = TAG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid_0,
  input  logic                       alloc_valid_1,
  input  logic [RD_W-1:0]            alloc_rd_0,
  input  logic [RD_W-1:0]            alloc_rd_1,
  input  logic                       alloc_has_rd_0,
  input  logic                       alloc_has_rd_1,
  input  logic [TAG_WIDTH-1:0]       alloc_preg_0,
  input  logic [TAG_WIDTH-1:0]       alloc_preg_1,
  input  logic [TAG_WIDTH-1:0]       alloc_old_preg_0,
  input  logic [TAG_WIDTH-1:0]       alloc_old_preg_1,
  output logic                       alloc_ready,
  output logic [$clog2(DEPTH)-1:0]   alloc_idx_0,
  output logic [$clog2(DEPTH)-1:0]   alloc_idx_1,
  input  logic                       wb_valid_0,
  input  logic                       wb_valid_1,
  input  logic [$clog2(DEPTH)-1:0]   wb_idx_0,
  input  logic [$clog2(DEPTH)-1:0]   wb_idx_1,
  input  logic                       flush,
  output logic                       commit_valid_0,
  output logic                       commit_valid_1,
  output logic [RD_W-1:0]            commit_rd_0,
  output logic [RD_W-1:0]            commit_rd_1,
  output logic [TAG_WIDTH-1:0]       commit_preg_0,
  output logic [TAG_WIDTH-1:0]       commit_preg_1,
  output logic                       free_valid,
  output logic [TAG_WIDTH-1:0]       free_preg,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Control state
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;

  // Entry payload (meaningless while the entry is invalid)
  logic [DEPTH-1:0]     has_rd_q;
  logic [RD_W-1:0]      rd_q       [DEPTH];
  logic [TAG_WIDTH-1:0] preg_q     [DEPTH];
  logic [TAG_WIDTH-1:0] old_preg_q [DEPTH];

  // Registered commit / free outputs
  logic                 cv0_q, cv0_d, cv1_q, cv1_d;
  logic [RD_W-1:0]      crd0_q, crd0_d, crd1_q, crd1_d;
  logic [TAG_WIDTH-1:0] cpreg0_q, cpreg0_d, cpreg1_q, cpreg1_d;
  logic                 fv_q, fv_d;
  logic [TAG_WIDTH-1:0] fpreg_q, fpreg_d;

  logic [IDX_W-1:0] head1, tail1;
  logic             do_alloc_0, do_alloc_1;
  logic             retire_0, retire_1, sel_free, free_from_1;
  logic [1:0]       n_alloc, n_commit;
  rob_status_t      head0_st, head1_st;

  assign head1 = head_q + IDX_W'(1);
  assign tail1 = tail_q + IDX_W'(1);

  // Admission looks only at the registered count; a commit in the same
  // cycle does not open a slot until the next cycle.
  assign alloc_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign alloc_idx_0 = tail_q;
  assign alloc_idx_1 = tail1;

  assign do_alloc_0 = alloc_valid_0 && alloc_ready;
  assign do_alloc_1 = do_alloc_0 && alloc_valid_1;

  assign head0_st = '{valid: valid_q[head_q], done: done_q[head_q], has_rd: has_rd_q[head_q]};
  assign head1_st = '{valid: valid_q[head1],  done: done_q[head1],  has_rd: has_rd_q[head1]};

  rob_commit_select u_commit_select (
    .head0_i       (head0_st),
    .head1_i       (head1_st),
    .retire_0_o    (retire_0),
    .retire_1_o    (retire_1),
    .free_valid_o  (sel_free),
    .free_from_1_o (free_from_1)
  );

  assign n_alloc  = add2(do_alloc_0, do_alloc_1);
  assign n_commit = add2(retire_0, retire_1);

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    head_d   = head_q + IDX_W'(n_commit);
    tail_d   = tail_q + IDX_W'(n_alloc);
    count_d  = count_q + CNT_W'(n_alloc) - CNT_W'(n_commit);

    // Completion marks only land on live entries.
    if (wb_valid_0 && valid_q[wb_idx_0]) done_d[wb_idx_0] = 1'b1;
    if (wb_valid_1 && valid_q[wb_idx_1]) done_d[wb_idx_1] = 1'b1;

    if (retire_0) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (retire_1) begin
      valid_d[head1] = 1'b0;
      done_d[head1]  = 1'b0;
    end

    // Allocation targets are always free entries because alloc_ready
    // guarantees two empty slots at tail and tail+1.
    if (do_alloc_0) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
    if (do_alloc_1) begin
      valid_d[tail1] = 1'b1;
      done_d[tail1]  = 1'b0;
    end

    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    cv0_d    = retire_0;
    cv1_d    = retire_1;
    crd0_d   = retire_0 ? rd_q[head_q]   : '0;
    cpreg0_d = retire_0 ? preg_q[head_q] : '0;
    crd1_d   = retire_1 ? rd_q[head1]    : '0;
    cpreg1_d = retire_1 ? preg_q[head1]  : '0;
    fv_d     = sel_free;
    fpreg_d  = '0;
    if (sel_free) fpreg_d = free_from_1 ? old_preg_q[head1] : old_preg_q[head_q];

    if (flush) begin
      cv0_d    = 1'b0;
      cv1_d    = 1'b0;
      crd0_d   = '0;
      cpreg0_d = '0;
      crd1_d   = '0;
      cpreg1_d = '0;
      fv_d     = 1'b0;
      fpreg_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc_0) begin
      has_rd_q[tail_q]   <= alloc_has_rd_0;
      rd_q[tail_q]       <= alloc_rd_0;
      preg_q[tail_q]     <= alloc_preg_0;
      old_preg_q[tail_q] <= alloc_old_preg_0;
    end
    if (do_alloc_1) begin
      has_rd_q[tail1]   <= alloc_has_rd_1;
      rd_q[tail1]       <= alloc_rd_1;
      preg_q[tail1]     <= alloc_preg_1;
      old_preg_q[tail1] <= alloc_old_preg_1;
    end
  end

  // Retirement stage boundary: commit/free results appear one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cv0_q    <= 1'b0;
      cv1_q    <= 1'b0;
      crd0_q   <= '0;
      crd1_q   <= '0;
      cpreg0_q <= '0;
      cpreg1_q <= '0;
      fv_q     <= 1'b0;
      fpreg_q  <= '0;
    end else begin
      cv0_q    <= cv0_d;
      cv1_q    <= cv1_d;
      crd0_q   <= crd0_d;
      crd1_q   <= crd1_d;
      cpreg0_q <= cpreg0_d;
      cpreg1_q <= cpreg1_d;
      fv_q     <= fv_d;
      fpreg_q  <= fpreg_d;
    end
  end

  assign commit_valid_0 = cv0_q;
  assign commit_valid_1 = cv1_q;
  assign commit_rd_0    = crd0_q;
  assign commit_rd_1    = crd1_q;
  assign commit_preg_0  = cpreg0_q;
  assign commit_preg_1  = cpreg1_q;
  assign free_valid     = fv_q;
  assign free_preg      = fpreg_q;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alloc_valid_0 = 0, alloc_valid_1 = 0;
  logic [4:0] alloc_rd_0 = 0, alloc_rd_1 = 0;
  logic       alloc_has_rd_0 = 0, alloc_has_rd_1 = 0;
  logic [5:0] alloc_preg_0 = 0, alloc_preg_1 = 0;
  logic [5:0] alloc_old_preg_0 = 0, alloc_old_preg_1 = 0;
  logic       alloc_ready;
  logic [3:0] alloc_idx_0, alloc_idx_1;
  logic       wb_valid_0 = 0, wb_valid_1 = 0;
  logic [3:0] wb_idx_0 = 0, wb_idx_1 = 0;
  logic       flush = 0;
  logic       commit_valid_0, commit_valid_1;
  logic [4:0] commit_rd_0, commit_rd_1;
  logic [5:0] commit_preg_0, commit_preg_1;
  logic       free_valid;
  logic [5:0] free_preg;
  logic [4:0] count;
  logic       empty, full;

  reorder_buffer #(.DEPTH(16), .TAG_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_0(alloc_valid_0), .alloc_valid_1(alloc_valid_1),
    .alloc_rd_0(alloc_rd_0), .alloc_rd_1(alloc_rd_1),
    .alloc_has_rd_0(alloc_has_rd_0), .alloc_has_rd_1(alloc_has_rd_1),
    .alloc_preg_0(alloc_preg_0), .alloc_preg_1(alloc_preg_1),
    .alloc_old_preg_0(alloc_old_preg_0), .alloc_old_preg_1(alloc_old_preg_1),
    .alloc_ready(alloc_ready), .alloc_idx_0(alloc_idx_0), .alloc_idx_1(alloc_idx_1),
    .wb_valid_0(wb_valid_0), .wb_valid_1(wb_valid_1),
    .wb_idx_0(wb_idx_0), .wb_idx_1(wb_idx_1),
    .flush(flush),
    .commit_valid_0(commit_valid_0), .commit_valid_1(commit_valid_1),
    .commit_rd_0(commit_rd_0), .commit_rd_1(commit_rd_1),
    .commit_preg_0(commit_preg_0), .commit_preg_1(commit_preg_1),
    .free_valid(free_valid), .free_preg(free_preg),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v0;
    logic [4:0] rd0;
    logic [5:0] p0;
    logic       v1;
    logic [4:0] rd1;
    logic [5:0] p1;
    logic       fv;
    logic [5:0] fp;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic ev_t mk(input int v0, input int rd0, input int p0,
                             input int v1, input int rd1, input int p1,
                             input int fv, input int fp);
    ev_t e;
    e.v0 = v0[0]; e.rd0 = rd0[4:0]; e.p0 = p0[5:0];
    e.v1 = v1[0]; e.rd1 = rd1[4:0]; e.p1 = p1[5:0];
    e.fv = fv[0]; e.fp = fp[5:0];
    return e;
  endfunction

  // Monitor: every cycle with any commit/free activity must match the
  // next expected retirement record.
  always @(negedge clk) begin : monitor
    ev_t act;
    ev_t e;
    if (commit_valid_0 === 1'b1 || commit_valid_1 === 1'b1 || free_valid === 1'b1) begin
      act = {commit_valid_0, commit_rd_0, commit_preg_0,
             commit_valid_1, commit_rd_1, commit_preg_1,
             free_valid, free_preg};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit at %0t: got %h required none", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL commit_record at %0t: got %h required %h", $time, act, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic alloc2(input int h0, input int r0, input int p0, input int o0,
                        input int h1, input int r1, input int p1, input int o1);
    alloc_valid_0 = 1; alloc_has_rd_0 = h0[0]; alloc_rd_0 = r0[4:0];
    alloc_preg_0 = p0[5:0]; alloc_old_preg_0 = o0[5:0];
    alloc_valid_1 = 1; alloc_has_rd_1 = h1[0]; alloc_rd_1 = r1[4:0];
    alloc_preg_1 = p1[5:0]; alloc_old_preg_1 = o1[5:0];
    step();
    alloc_valid_0 = 0; alloc_valid_1 = 0;
  endtask

  task automatic wb2(input int v0, input int i0, input int v1, input int i1);
    wb_valid_0 = v0[0]; wb_idx_0 = i0[3:0];
    wb_valid_1 = v1[0]; wb_idx_1 = i1[3:0];
    step();
    wb_valid_0 = 0; wb_valid_1 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle(2);
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_idx_0", alloc_idx_0, 0);
    chk("rst_alloc_idx_1", alloc_idx_1, 1);
    chk("rst_commit_valid_0", commit_valid_0, 0);
    chk("rst_free_valid", free_valid, 0);

    // Basic pair, both write registers: retire one per cycle
    exp_q.push_back(mk(1, 1, 33, 0, 0, 0, 1, 1));
    exp_q.push_back(mk(1, 2, 34, 0, 0, 0, 1, 2));
    alloc2(1, 1, 33, 1, 1, 2, 34, 2);
    chk("t1_count_after_alloc", count, 2);
    chk("t1_alloc_idx_0", alloc_idx_0, 2);
    wb2(1, 0, 1, 1);
    chk("t1_no_commit_on_wb_edge", count, 2);
    step();
    chk("t1_commit_valid_0", commit_valid_0, 1);
    chk("t1_commit_valid_1", commit_valid_1, 0);
    chk("t1_free_preg", free_preg, 1);
    chk("t1_count_mid", count, 1);
    idle(3);
    chk("t1_count_end", count, 0);
    chk("t1_empty_end", empty, 1);

    // Only slot 1 writes a register: dual retire, free from slot 1
    chk("t2_alloc_idx_0", alloc_idx_0, 2);
    exp_q.push_back(mk(1, 3, 35, 1, 4, 36, 1, 4));
    alloc2(0, 3, 35, 3, 1, 4, 36, 4);
    wb2(1, 2, 1, 3);
    idle(3);
    chk("t2_count_end", count, 0);

    // Out-of-order completion; both wb ports hit the same index
    alloc2(1, 5, 37, 5, 0, 6, 38, 6);
    wb2(1, 5, 1, 5);
    idle(3);
    chk("t3_held_behind_head", count, 2);
    exp_q.push_back(mk(1, 5, 37, 1, 6, 38, 1, 5));
    wb2(0, 0, 1, 4);
    idle(3);
    chk("t3_count_end", count, 0);

    // Fill to full, overflow attempt, drain, wrap
    do_reset();
    for (int k = 0; k < 8; k++) begin
      chk("t4_alloc_idx_0", alloc_idx_0, 2 * k);
      chk("t4_alloc_idx_1", alloc_idx_1, 2 * k + 1);
      alloc2(1, 2 * k + 1, 40 + 2 * k, 20 + 2 * k, 1, 2 * k + 2, 41 + 2 * k, 21 + 2 * k);
    end
    chk("t4_count_full", count, 16);
    chk("t4_full", full, 1);
    chk("t4_alloc_ready_low", alloc_ready, 0);
    chk("t4_tail_wrapped", alloc_idx_0, 0);
    alloc2(1, 30, 60, 30, 1, 31, 61, 31);
    chk("t4_overflow_ignored", count, 16);
    for (int k = 0; k < 14; k++) exp_q.push_back(mk(1, k + 1, 40 + k, 0, 0, 0, 1, 20 + k));
    for (int j = 0; j < 7; j++) wb2(1, 2 * j, 1, 2 * j + 1);
    for (int c = 0; c < 40 && count != 2; c++) step();
    chk("t4_drained_to_two", count, 2);
    chk("t4_alloc_ready_back", alloc_ready, 1);
    for (int k = 14; k < 16; k++) exp_q.push_back(mk(1, k + 1, 40 + k, 0, 0, 0, 1, 20 + k));
    wb2(1, 14, 1, 15);
    idle(4);
    chk("t4_count_end", count, 0);
    chk("t4_tail_at_zero", alloc_idx_0, 0);

    // Flush with pending entries and same-cycle alloc + wb
    for (int k = 0; k < 3; k++) alloc2(1, 10 + k, 10 + k, k, 1, 20 + k, 20 + k, k);
    chk("t5_count_before", count, 6);
    flush = 1;
    alloc_valid_0 = 1; alloc_valid_1 = 1;
    wb_valid_0 = 1; wb_idx_0 = 0; wb_valid_1 = 1; wb_idx_1 = 1;
    step();
    flush = 0; alloc_valid_0 = 0; alloc_valid_1 = 0; wb_valid_0 = 0; wb_valid_1 = 0;
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    chk("t5_tail_cleared", alloc_idx_0, 0);
    chk("t5_commit_valid_0", commit_valid_0, 0);
    chk("t5_free_valid", free_valid, 0);
    wb2(1, 0, 1, 1);
    idle(3);
    chk("t5_stale_wb_ignored", count, 0);

    // Reset while head is done: nothing retires
    alloc2(1, 7, 50, 7, 1, 8, 51, 8);
    wb2(1, 0, 1, 1);
    rst = 1;
    step();
    chk("t6_commit_valid_0", commit_valid_0, 0);
    chk("t6_commit_valid_1", commit_valid_1, 0);
    chk("t6_free_valid", free_valid, 0);
    chk("t6_free_preg", free_preg, 0);
    chk("t6_commit_rd_0", commit_rd_0, 0);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_alloc_ready", alloc_ready, 1);
    rst = 0;
    idle(4);

    chk("all_expected_commits_seen", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, 16, number of ROB entries (power of two).
REQ-002 Parameter TAG_WIDTH, 6, physical register tag width.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 alloc_valid_0 / alloc_valid_1  in  1  dispatch request, slot 0 / slot 1.
REQ-006 alloc_rd_0 / alloc_rd_1  in  5  architectural destination.
REQ-007 alloc_has_rd_0 / alloc_has_rd_1  in  1  instruction writes a register.
REQ-008 alloc_preg_0 / alloc_preg_1  in  TAG_WIDTH  newly allocated physical destination.
REQ-009 alloc_old_preg_0 / alloc_old_preg_1  in  TAG_WIDTH  previous mapping, freed at commit.
REQ-010 alloc_ready  out  1  at least two free entries.
REQ-011 alloc_idx_0 / alloc_idx_1  out  log2(DEPTH)  ROB index assigned to slot 0 / slot 1.
REQ-012 wb_valid_0 / wb_valid_1, wb_idx_0 / wb_idx_1  in  1 / log2(DEPTH)  execution-complete marks.
REQ-013 flush  in  1  discard all entries.
REQ-014 commit_valid_0 / commit_valid_1, commit_rd_*, commit_preg_*  out  1/5/TAG_WIDTH  retire to rename map.
REQ-015 free_valid, free_preg  out  1 / TAG_WIDTH  return one old physical register to the freelist.
REQ-016 count  out  log2(DEPTH)+1  occupied entries; empty, full  out  1.

Function
REQ-017 Circular buffer; head, tail pointers wrap modulo DEPTH; entry holds valid, done, has_rd, rd, preg, old_preg.
REQ-018 alloc_ready = (count <= DEPTH-2), from registered count only; same-cycle commits are not credited.
REQ-019 alloc_idx_0 = tail, alloc_idx_1 = tail+1 (mod DEPTH), combinational.
REQ-020 Slot 0 allocates at tail when alloc_valid_0 && alloc_ready; slot 1 allocates at tail+1 only if slot 0 also allocates; alloc_valid_1 alone is ignored.
REQ-021 Allocated entry: valid=1, done=0; tail advances by number allocated.
REQ-022 wb_valid_x sets done of entry wb_idx_x if valid; writeback to an invalid entry is ignored; both ports to the same index is legal.
REQ-023 Commit decision uses registered done bits; writeback to head commits no earlier than the following cycle.
REQ-024 Slot 0 retires head when valid && done; slot 1 retires head+1 when slot 0 retires, head+1 valid && done, and not (both has_rd) (single free port).
REQ-025 Commit outputs are registered: asserted the cycle after retirement, one cycle wide, carrying rd and preg of retired entries in program order.
REQ-026 free_valid asserts with commit of the single retiring entry having has_rd; free_preg = its old_preg.
REQ-027 count updates by +allocs -commits in the same edge; full = (count == DEPTH); empty = (count == 0).
REQ-028 flush has priority: all valid bits, head, tail, count cleared; same-cycle alloc, writeback, commit discarded; commit/free outputs 0 next cycle.

Reset
REQ-029 On rst: head=tail=count=0, all valid/done=0, commit_valid_*, free_valid=0, commit_rd/preg, free_preg=0, empty=1, full=0, alloc_ready=1.
REQ-030 rst mid-operation abandons in-flight entries; no commit or free issued for them.

Structure
REQ-031 DEPTH, TAG_WIDTH, ARCH register count and entry field widths live in shared package superscalar_pkg.
REQ-032 Commit selection (REQ-024, REQ-026) is sub-module rob_commit_select, purely combinational; storage and pointers stay in reorder_buffer.

Verification
REQ-033 Reset, alloc two (rd=1/preg=33/old=1, rd=2/preg=34/old=2), wb both -> next cycle retire; following cycle commit_valid_0=1 rd=1 preg=33, commit_valid_1=0, free_preg=1; then rd=2 retires.
REQ-034 Alloc two with has_rd_0=0, has_rd_1=1, both wb -> both commit same cycle, free_valid=1, free_preg=slot-1 old_preg.
REQ-035 Out-of-order wb: wb index 1 before index 0 -> no commit until index 0 done, then both in order.
REQ-036 Allocate 8 pairs without wb -> count=16, full=1, alloc_ready=0; further allocs ignored; after 14 entries drain, alloc_ready=1; tail wraps to 0.
REQ-037 flush with 6 entries pending and same-cycle alloc+wb -> count=0, empty=1, no commit/free next cycle.
REQ-038 rst asserted with head entry done -> no commit output; outputs at reset values next cycle.
